// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator, updated once per sample_tick.
// Define ENVELOPE_EXP_RELEASE_EN for an exponential-like release; default is linear.
module adsr_envelope #(
  parameter int PERCENT_WIDTH  = 7,
  parameter int ENVELOPE_WIDTH = 16,
  parameter int STEP_SHIFT     = 2
) (
  input  logic                      clock,
  input  logic                      reset_l,
  input  logic                      sample_tick,
  input  logic                      gate,
  input  logic [PERCENT_WIDTH-1:0]  attack_time,
  input  logic [PERCENT_WIDTH-1:0]  decay_time,
  input  logic [PERCENT_WIDTH-1:0]  sustain_level,
  input  logic [PERCENT_WIDTH-1:0]  release_time,
  output logic [ENVELOPE_WIDTH-1:0] envelope,
  output logic                      envelope_valid,
  output logic                      active
);

  localparam int SW = ENVELOPE_WIDTH + 1;
  localparam logic [SW-1:0] FULL_SCALE = {1'b0, {ENVELOPE_WIDTH{1'b1}}};

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} state_t;

  state_t state;

  // Larger time value means a slower ramp: step = (2^P - t) << STEP_SHIFT.
  function automatic logic [SW-1:0] rate_step(input logic [PERCENT_WIDTH-1:0] t);
    return (SW'(2**PERCENT_WIDTH) - SW'(t)) << STEP_SHIFT;
  endfunction

  logic [ENVELOPE_WIDTH-1:0] sustain_target;
  logic [SW-1:0]             level_ext, atk_sum, dec_raw, dec_sat, rel_step, rel_raw;
  logic                      atk_full, dec_hit, rel_done;

  // Replicate the sustain level MSB-first across the level width so full scale gives all-ones.
  always_comb begin
    sustain_target = '0;
    for (int i = 0; i < ENVELOPE_WIDTH; i++)
      sustain_target[ENVELOPE_WIDTH-1-i] = sustain_level[PERCENT_WIDTH-1-(i % PERCENT_WIDTH)];
  end

  always_comb begin
    level_ext = {1'b0, envelope};
    atk_sum   = level_ext + rate_step(attack_time);
    atk_full  = atk_sum >= FULL_SCALE;
    dec_raw   = level_ext - rate_step(decay_time);
    dec_sat   = dec_raw[SW-1] ? '0 : dec_raw;
    dec_hit   = dec_sat <= {1'b0, sustain_target};
`ifdef ENVELOPE_EXP_RELEASE_EN
    rel_step  = (level_ext >> (3 + release_time[PERCENT_WIDTH-1 -: 3])) + SW'(1);
`else
    rel_step  = rate_step(release_time);
`endif
    rel_raw   = level_ext - rel_step;
    rel_done  = rel_raw[SW-1] || (rel_raw == '0);
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      envelope       <= '0;
      envelope_valid <= 1'b0;
      active         <= 1'b0;
    end else begin
      envelope_valid <= sample_tick;
      if (sample_tick) begin
        case (state)
          IDLE: if (gate) begin
            state  <= ATTACK;
            active <= 1'b1;
          end
          ATTACK:
            if (!gate) state <= RELEASE;
            else if (atk_full) begin
              envelope <= FULL_SCALE[ENVELOPE_WIDTH-1:0];
              state    <= DECAY;
            end else envelope <= atk_sum[ENVELOPE_WIDTH-1:0];
          DECAY:
            if (!gate) state <= RELEASE;
            else if (dec_hit) begin
              envelope <= sustain_target;
              state    <= SUSTAIN;
            end else envelope <= dec_sat[ENVELOPE_WIDTH-1:0];
          SUSTAIN:
            if (!gate) state <= RELEASE;
            else envelope <= sustain_target;
          RELEASE:
            // Re-attack continues from the current level rather than restarting at 0.
            if (gate) state <= ATTACK;
            else if (rel_done) begin
              envelope <= '0;
              state    <= IDLE;
              active   <= 1'b0;
            end else envelope <= rel_raw[ENVELOPE_WIDTH-1:0];
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
